// File: rtl/ss_scan_if.sv
// ss_scan_if: display data in, multiplexed segment/anode drive out
interface ss_scan_if;
  logic            en;
  logic [6:0]      seg0;
  logic [6:0]      seg1;
  logic [6:0]      seg2;
  logic [6:0]      seg3;
  logic [3:0]      dp_in;
  logic [3:0]      digit_en;
  logic [6:0]      seg_out;
  logic            dp_out;
  logic [3:0]      an;
  logic            frame_done;
  modport master (
    output en, seg0, seg1, seg2, seg3, dp_in, digit_en,
    input  seg_out, dp_out, an, frame_done
  );
  modport slave (
    input  en, seg0, seg1, seg2, seg3, dp_in, digit_en,
    output seg_out, dp_out, an, frame_done
  );
endinterface

// File: rtl/ss_scan_ctrl.sv
// ss_scan_ctrl: 4-digit seven-segment scanner with blanking gap and per-frame snapshot
module ss_scan_ctrl #(
  parameter int DIGIT_CYCLES = 25000,
  parameter int BLANK_CYCLES = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  ss_scan_if.slave   bus
);
  localparam int MAXC = DIGIT_CYCLES > BLANK_CYCLES ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DLOAD = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLOAD = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
  state_t          state, n_state;
  logic [1:0]      idx, n_idx;
  logic [CW-1:0]   cnt, n_cnt;
  logic [3:0][6:0] sh_seg, n_seg;
  logic [3:0]      sh_dp, n_dp, sh_en, n_en;
  logic            slot_end, wrap, cap, lit;
  // next-state and next-output decode; outputs are computed from the state being entered
  always_comb begin
    slot_end = cnt == '0;
    wrap     = state == DRIVE && slot_end && idx == 2'd3 && bus.en;
    cap      = (state == IDLE && bus.en) || wrap;
    n_seg    = cap ? {bus.seg3, bus.seg2, bus.seg1, bus.seg0} : sh_seg;
    n_dp     = cap ? bus.dp_in : sh_dp;
    n_en     = cap ? bus.digit_en : sh_en;
    n_state  = !bus.en ? IDLE :
               (state == IDLE || (state == DRIVE && slot_end)) ? (BLANK_CYCLES > 0 ? BLANK : DRIVE) :
               (state == BLANK && slot_end) ? DRIVE : state;
    n_idx    = (!bus.en || state == IDLE) ? 2'd0 :
               (state == DRIVE && slot_end) ? idx + 2'd1 : idx;
    n_cnt    = n_state == IDLE ? '0 :
               slot_end ? (n_state == BLANK ? BLOAD : DLOAD) : cnt - CW'(1);
    lit      = n_state == DRIVE && n_en[n_idx];
  end
  // state, snapshot and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      sh_seg         <= {4{7'h7F}};
      sh_dp          <= '0;
      sh_en          <= '0;
      bus.an         <= 4'hF;
      bus.seg_out    <= 7'h7F;
      bus.dp_out     <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= n_state;
      idx            <= n_idx;
      cnt            <= n_cnt;
      sh_seg         <= n_seg;
      sh_dp          <= n_dp;
      sh_en          <= n_en;
      bus.an         <= lit ? ~(4'b0001 << n_idx) : 4'hF;
      bus.seg_out    <= lit ? n_seg[n_idx] : 7'h7F;
      bus.dp_out     <= lit ? ~n_dp[n_idx] : 1'b1;
      bus.frame_done <= wrap;
    end
  end
endmodule

// File: tb/tb_ss_scan_ctrl.sv
// tb_ss_scan_ctrl: scoreboard bench for two scanner instances (blank gap 2 and 0)
module tb_ss_scan_ctrl;
  localparam int D = 4;
  localparam logic [12:0] DARK = {4'hF, 7'h7F, 1'b1, 1'b0};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic            en;
  logic [3:0][6:0] seg;
  logic [3:0]      dp, den;
  int checks = 0;
  int errors = 0;
  ss_scan_if b2 ();
  ss_scan_if b0 ();
  assign b2.en = en;       assign b0.en = en;
  assign b2.seg0 = seg[0]; assign b0.seg0 = seg[0];
  assign b2.seg1 = seg[1]; assign b0.seg1 = seg[1];
  assign b2.seg2 = seg[2]; assign b0.seg2 = seg[2];
  assign b2.seg3 = seg[3]; assign b0.seg3 = seg[3];
  assign b2.dp_in = dp;    assign b0.dp_in = dp;
  assign b2.digit_en = den; assign b0.digit_en = den;
  ss_scan_ctrl #(.DIGIT_CYCLES(D), .BLANK_CYCLES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  ss_scan_ctrl #(.DIGIT_CYCLES(D), .BLANK_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  // reference model: position within the frame decides what is shown
  int              bl [2] = '{2, 0};
  bit              act [2];
  int              t [2];
  logic [3:0][6:0] sseg [2];
  logic [3:0]      sdp [2];
  logic [3:0]      sen [2];
  logic [12:0]     qa [$];
  logic [12:0]     qb [$];
  function automatic logic [12:0] expv(int m, logic fd);
    int s, slot, pos;
    logic [3:0] a;
    if (!act[m]) return DARK;
    s = bl[m] + D;
    slot = t[m] / s;
    pos = t[m] % s;
    if (pos < bl[m] || !sen[m][slot]) return {4'hF, 7'h7F, 1'b1, fd};
    a = 4'b0001 << slot;
    return {~a, sseg[m][slot], ~sdp[m][slot], fd};
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act = '{0, 0};
      qa.delete();
      qb.delete();
    end else begin
      for (int m = 0; m < 2; m++) begin
        logic fd;
        fd = 1'b0;
        if (!en) act[m] = 0;
        else if (!act[m]) begin
          act[m] = 1; t[m] = 0; sseg[m] = seg; sdp[m] = dp; sen[m] = den;
        end else begin
          t[m] = (t[m] + 1) % (4 * (bl[m] + D));
          if (t[m] == 0) begin
            sseg[m] = seg; sdp[m] = dp; sen[m] = den; fd = 1'b1;
          end
        end
        if (m == 0) qa.push_back(expv(0, fd));
        else qb.push_back(expv(1, fd));
      end
    end
  end
  task automatic chk(string nm, logic [12:0] got, logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got an=%h seg=%h dp=%b fd=%b exp an=%h seg=%h dp=%b fd=%b t=%0t",
               nm, got[12:9], got[8:2], got[1], got[0], exp[12:9], exp[8:2], exp[1], exp[0], $time);
    end
  endtask
  task automatic chk_an(string nm, logic [3:0] a);
    checks++;
    if ($countones(~a) > 1) begin
      errors++;
      $display("FAIL %s overlap an=%h exp at most one zero bit", nm, a);
    end
  endtask
  // monitor: compare every presented output cycle against the scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_b2", {b2.an, b2.seg_out, b2.dp_out, b2.frame_done}, DARK);
      chk("rst_b0", {b0.an, b0.seg_out, b0.dp_out, b0.frame_done}, DARK);
    end else begin
      if (qa.size() > 0) chk("scan_b2", {b2.an, b2.seg_out, b2.dp_out, b2.frame_done}, qa.pop_front());
      if (qb.size() > 0) chk("scan_b0", {b0.an, b0.seg_out, b0.dp_out, b0.frame_done}, qb.pop_front());
    end
    chk_an("an_b2", b2.an);
    chk_an("an_b0", b0.an);
  end
  initial begin
    en = 1'b0; seg = '0; dp = 4'h0; den = 4'hF;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    seg = {7'h30, 7'h24, 7'h79, 7'h40};
    en = 1'b1;
    repeat (10) @(negedge clk);
    seg[1] = 7'h12;
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_b2", {b2.an, b2.seg_out, b2.dp_out, b2.frame_done}, DARK);
    chk("async_b0", {b0.an, b0.seg_out, b0.dp_out, b0.frame_done}, DARK);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    den = 4'b0101; dp = 4'b0001;
    repeat (60) @(negedge clk);
    begin
      int n;
      n = 0;
      while (b2.an !== 4'hB && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (n >= 40) begin
        errors++;
        $display("FAIL wait_digit2 got an=%h exp an=b within 40 cycles", b2.an);
      end
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      seg = {7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom)};
      dp = 4'($urandom);
      den = 4'($urandom);
      if ($urandom_range(5) == 0) en = ~en;
      repeat ($urandom_range(40, 1)) @(negedge clk);
    end
    en = 1'b1;
    repeat (60) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
